// File: rtl/rb_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the 8-bit register-bank bus.
// Masters see a req/ack handshake; the bank's registered read latency is absorbed here.
module rb_bus_arbiter #(
  parameter int unsigned ADR_BITS = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADR_BITS-1:0] m0_addr,
  input  logic [7:0]          m0_wdata,
  output logic                m0_ack,
  output logic [7:0]          m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADR_BITS-1:0] m1_addr,
  input  logic [7:0]          m1_wdata,
  output logic                m1_ack,
  output logic [7:0]          m1_rdata,
  output logic [ADR_BITS-1:0] address,
  output logic [7:0]          data_write_in,
  input  logic [7:0]          data_read_out,
  output logic                reg_en,
  output logic                write_en,
  output logic                busy,
  output logic                grant
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sel;
  logic [ADR_BITS-1:0] address_d;
  logic [DATA_W-1:0]   data_write_in_d, m0_rdata_d, m1_rdata_d;
  logic                reg_en_d, write_en_d, busy_d, grant_d, m0_ack_d, m1_ack_d;

  // Next-state and next-output logic; every output is the registered copy of a *_d value.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    we_d            = we_q;
    cnt_d           = cnt_q;
    sel             = 1'b0;
    address_d       = address;
    data_write_in_d = data_write_in;
    reg_en_d        = 1'b0;
    write_en_d      = 1'b0;
    grant_d         = grant;
    m0_ack_d        = 1'b0;
    m1_ack_d        = 1'b0;
    m0_rdata_d      = m0_rdata;
    m1_rdata_d      = m1_rdata;
    busy_d          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // A tie goes to the master that was not served last.
          sel             = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          we_d            = sel ? m1_we : m0_we;
          address_d       = sel ? m1_addr : m0_addr;
          data_write_in_d = sel ? m1_wdata : m0_wdata;
          grant_d         = sel;
          last_grant_d    = sel;
          reg_en_d        = 1'b1;
          write_en_d      = we_d;
          state_d         = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          m0_ack_d = ~grant;
          m1_ack_d = grant;
          state_d  = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Bank data is valid in the cycle the counter reaches 1.
        if (cnt_q == CNT_W'(1)) begin
          if (grant) m1_rdata_d = data_read_out;
          else       m0_rdata_d = data_read_out;
          m0_ack_d = ~grant;
          m1_ack_d = grant;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      address       <= '0;
      data_write_in <= '0;
      reg_en        <= 1'b0;
      write_en      <= 1'b0;
      busy          <= 1'b0;
      grant         <= 1'b0;
      m0_ack        <= 1'b0;
      m1_ack        <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      address       <= address_d;
      data_write_in <= data_write_in_d;
      reg_en        <= reg_en_d;
      write_en      <= write_en_d;
      busy          <= busy_d;
      grant         <= grant_d;
      m0_ack        <= m0_ack_d;
      m1_ack        <= m1_ack_d;
      m0_rdata      <= m0_rdata_d;
      m1_rdata      <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_rb_bus_arbiter.sv
// Bench for rb_bus_arbiter: two instances (read latency 1 and 3) driven by master models,
// each with a bank model, checked every cycle against a transaction-timeline reference.
module tb_rb_bus_arbiter;
  localparam int unsigned LAT0   = 1;
  localparam int unsigned LAT1   = 3;
  localparam int          ACK_TO = 100;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         exp_lat;
    logic       chk_rd;
    logic [7:0] exp_rd;
  } txn_t;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  logic       req   [2][2];
  logic       we    [2][2];
  logic [7:0] addr  [2][2];
  logic [7:0] wdata [2][2];
  logic       ack   [2][2];
  logic [7:0] rdata [2][2];
  logic [7:0] address [2];
  logic [7:0] data_write_in [2];
  logic [7:0] data_read_out [2];
  logic       reg_en [2];
  logic       write_en [2];
  logic       busy [2];
  logic       grant [2];

  rb_bus_arbiter #(.ADR_BITS(8), .RD_LAT(LAT0)) u_dut_lat1 (
    .clk(clk), .resetb(resetb),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
    .address(address[0]), .data_write_in(data_write_in[0]), .data_read_out(data_read_out[0]),
    .reg_en(reg_en[0]), .write_en(write_en[0]), .busy(busy[0]), .grant(grant[0])
  );

  rb_bus_arbiter #(.ADR_BITS(8), .RD_LAT(LAT1)) u_dut_lat3 (
    .clk(clk), .resetb(resetb),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
    .address(address[1]), .data_write_in(data_write_in[1]), .data_read_out(data_read_out[1]),
    .reg_en(reg_en[1]), .write_en(write_en[1]), .busy(busy[1]), .grant(grant[1])
  );

  function automatic logic [7:0] seed_val(input int i, input int a);
    return 8'(a * 37 + i * 101 + 5);
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  // Register bank: registered read, data appears RD_LAT cycles after the address cycle.
  logic [7:0] bank [2][256];
  logic [7:0] pipe [2][4];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetb) begin
        for (int a = 0; a < 256; a++) bank[i][a] <= seed_val(i, a);
      end else if (reg_en[i] && write_en[i]) begin
        bank[i][address[i]] <= data_write_in[i];
      end
      pipe[i][0] <= reg_en[i] ? bank[i][address[i]] : 8'($urandom);
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end
  assign data_read_out[0] = pipe[0][LAT0-1];
  assign data_read_out[1] = pipe[1][LAT1-1];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: current transaction timeline plus expected held outputs.
  bit         t_valid [2];
  bit         t_w     [2];
  bit         t_we    [2];
  logic [7:0] t_rd    [2];
  int         t_acc   [2];
  int         t_ack   [2];
  bit         m_last  [2];
  logic       m_grant [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2][2];
  logic [7:0] gmem    [2][256];

  txn_t q       [2][2][$];
  txn_t cur     [2][2];
  bit   pend    [2][2];
  int   issue_c [2][2];
  bit   rand_mode;
  logic glog    [2][$];

  function automatic txn_t mk(input logic w, input logic [7:0] a, input logic [7:0] d,
                              input int el, input logic chk, input logic [7:0] rd);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d; t.exp_lat = el; t.chk_rd = chk; t.exp_rd = rd;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t_valid[i] = 1'b0; m_last[i] = 1'b1; m_grant[i] = 1'b0;
      m_addr[i] = 8'h00; m_wdata[i] = 8'h00;
      for (int a = 0; a < 256; a++) gmem[i][a] = seed_val(i, a);
      for (int m = 0; m < 2; m++) begin
        m_rdata[i][m] = 8'h00; pend[i][m] = 1'b0; q[i][m].delete();
        req[i][m] = 1'b0; we[i][m] = 1'b0; addr[i][m] = 8'h00; wdata[i][m] = 8'h00;
      end
    end
  endtask

  task automatic check_outputs(input int i);
    string p;
    bit e_acc, e_ack, e_busy;
    p      = (i == 0) ? "u_lat1" : "u_lat3";
    e_acc  = t_valid[i] && (cyc == t_acc[i]);
    e_ack  = t_valid[i] && (cyc == t_ack[i]);
    e_busy = t_valid[i] && (cyc >= t_acc[i]) && (cyc <= t_ack[i]);
    if (e_ack && !t_we[i]) m_rdata[i][t_w[i]] = t_rd[i];
    check_value({p, ".busy"},     32'(busy[i]),          32'(e_busy));
    check_value({p, ".reg_en"},   32'(reg_en[i]),        32'(e_acc));
    check_value({p, ".write_en"}, 32'(write_en[i]),      32'(e_acc && t_we[i]));
    check_value({p, ".grant"},    32'(grant[i]),         32'(m_grant[i]));
    check_value({p, ".address"},  32'(address[i]),       32'(m_addr[i]));
    check_value({p, ".wdata"},    32'(data_write_in[i]), 32'(m_wdata[i]));
    check_value({p, ".m0_ack"},   32'(ack[i][0]),        32'(e_ack && !t_w[i]));
    check_value({p, ".m1_ack"},   32'(ack[i][1]),        32'(e_ack && t_w[i]));
    check_value({p, ".m0_rdata"}, 32'(rdata[i][0]),      32'(m_rdata[i][0]));
    check_value({p, ".m1_rdata"}, 32'(rdata[i][1]),      32'(m_rdata[i][1]));
    if (reg_en[i] === 1'b1) glog[i].push_back(grant[i]);
  endtask

  task automatic drive_masters(input int i);
    string p;
    p = (i == 0) ? "u_lat1" : "u_lat3";
    for (int m = 0; m < 2; m++) begin
      if (pend[i][m] && ack[i][m] === 1'b1) begin
        pend[i][m] = 1'b0;
        if (cur[i][m].exp_lat != 0)
          check_value({p, (m == 0) ? ".m0" : ".m1", ".latency"},
                      32'(cyc - issue_c[i][m]), 32'(cur[i][m].exp_lat));
        if (cur[i][m].chk_rd)
          check_value({p, (m == 0) ? ".m0" : ".m1", ".read_data"},
                      32'(rdata[i][m]), 32'(cur[i][m].exp_rd));
      end else if (pend[i][m] && (cyc - issue_c[i][m]) > ACK_TO) begin
        check_value({p, ".ack_timeout"}, 32'(pend[i][m]), 32'(0));
        pend[i][m] = 1'b0;
      end
      if (!pend[i][m]) begin
        if (q[i][m].size() > 0) begin
          cur[i][m] = q[i][m].pop_front();
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          cur[i][m] = mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 0, 1'b0, 8'h00);
        end else begin
          req[i][m] = 1'b0; we[i][m] = 1'($urandom);
          addr[i][m] = 8'($urandom); wdata[i][m] = 8'($urandom);
          continue;
        end
        req[i][m] = 1'b1; we[i][m] = cur[i][m].we;
        addr[i][m] = cur[i][m].addr; wdata[i][m] = cur[i][m].wdata;
        issue_c[i][m] = cyc; pend[i][m] = 1'b1;
      end
    end
  endtask

  // Arbitration decision from the round-robin rule and the latency formulas.
  task automatic model_arbitrate(input int i);
    bit w;
    if (t_valid[i] && cyc <= t_ack[i]) return;
    if (req[i][0] !== 1'b1 && req[i][1] !== 1'b1) return;
    if (req[i][0] === 1'b1 && req[i][1] === 1'b1) w = !m_last[i];
    else w = (req[i][1] === 1'b1);
    t_valid[i] = 1'b1; t_w[i] = w; t_we[i] = we[i][w];
    t_acc[i] = cyc + 1;
    t_ack[i] = we[i][w] ? cyc + 2 : cyc + 2 + lat(i);
    if (we[i][w]) gmem[i][addr[i][w]] = wdata[i][w];
    else t_rd[i] = gmem[i][addr[i][w]];
    m_last[i] = w; m_grant[i] = w; m_addr[i] = addr[i][w]; m_wdata[i] = wdata[i][w];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      drive_masters(i);
      model_arbitrate(i);
    end
  endtask

  task automatic push(input int m, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int lat_fix, input bit add_rd_lat, input logic chk, input logic [7:0] rd);
    for (int i = 0; i < 2; i++)
      q[i][m].push_back(mk(w, a, d, (lat_fix == 0) ? 0 : lat_fix + (add_rd_lat ? lat(i) : 0), chk, rd));
  endtask

  task automatic run_quiet();
    bit quiet = 1'b0;
    for (int n = 0; n < 400 && !quiet; n++) begin
      step();
      quiet = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (t_valid[i] && cyc <= t_ack[i]) quiet = 1'b0;
        for (int m = 0; m < 2; m++)
          if (q[i][m].size() != 0 || pend[i][m]) quiet = 1'b0;
      end
    end
    check_value("drain", 32'(quiet), 32'(1));
    step();
    step();
  endtask

  task automatic check_grants(input string tag, input int n);
    for (int i = 0; i < 2; i++) begin
      check_value({tag, ".count"}, 32'(glog[i].size()), 32'(n));
      for (int k = 0; k < n && k < glog[i].size(); k++)
        check_value({tag, ".order"}, 32'(glog[i][k]), 32'(k % 2));
      glog[i].delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    resetb    = 1'b0;
    rand_mode = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    step();
    step();

    // Simultaneous requests straight after reset: master 0 first, then master 1.
    for (int i = 0; i < 2; i++) glog[i].delete();
    push(0, 1'b1, 8'h40, 8'h1F, 2, 1'b0, 1'b0, 8'h00);
    push(1, 1'b1, 8'h02, 8'h0F, 5, 1'b0, 1'b0, 8'h00);
    run_quiet();
    check_grants("both_first", 2);

    push(0, 1'b1, 8'h01, 8'h85, 2, 1'b0, 1'b0, 8'h00);
    run_quiet();
    push(0, 1'b0, 8'h02, 8'h00, 2, 1'b1, 1'b1, 8'h0F);
    run_quiet();
    push(1, 1'b0, 8'h40, 8'h00, 2, 1'b1, 1'b1, 8'h1F);
    run_quiet();

    // Both masters requesting back to back: strict alternation.
    for (int i = 0; i < 2; i++) glog[i].delete();
    for (int k = 0; k < 3; k++) begin
      push(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 0, 1'b0, 1'b0, 8'h00);
      push(1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 0, 1'b0, 1'b0, 8'h00);
    end
    run_quiet();
    check_grants("alternate", 6);

    // Reset while a master 0 read sits in RD_WAIT.
    push(0, 1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 8'h00);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (t_valid[0] && cyc == t_acc[0] + 1) found = 1'b1;
    end
    check_value("reach_rd_wait", 32'(found), 32'(1));
    #1;
    resetb = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_value("async_reset.ctl",
                  32'({busy[i], reg_en[i], write_en[i], grant[i], ack[i][0], ack[i][1],
                       address[i], data_write_in[i]}), 32'(0));
      check_value("async_reset.rdata", 32'({rdata[i][0], rdata[i][1]}), 32'(0));
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    push(0, 1'b1, 8'h33, 8'h5A, 2, 1'b0, 1'b0, 8'h00);
    run_quiet();
    push(0, 1'b0, 8'h33, 8'h00, 2, 1'b1, 1'b1, 8'h5A);
    run_quiet();

    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    run_quiet();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
